// File: rtl/dmem_stbuf_pkg.sv
// Shared constants and entry type for the data-memory store buffer.
// AW/DW defaults are shared with the data-memory instance.
package dmem_stbuf_pkg;

    localparam int STBUF_DEPTH = 4;
    localparam int STBUF_AW    = 6;
    localparam int STBUF_DW    = 32;
    localparam int STBUF_PTR_W = $clog2(STBUF_DEPTH);
    localparam int STBUF_CNT_W = STBUF_PTR_W + 1;

    typedef struct packed {
        logic                valid;
        logic [STBUF_AW-1:0] addr;
        logic [STBUF_DW-1:0] data;
    } entry_t;

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Core-side and memory-side signals of the store buffer.
// slave = the buffer itself, master = the core/memory environment.
interface dmem_store_buffer_if;
    import dmem_stbuf_pkg::*;

    logic                cpu_we;
    logic                cpu_re;
    logic [STBUF_AW-1:0] cpu_a;
    logic [STBUF_DW-1:0] cpu_d;
    logic [STBUF_DW-1:0] cpu_q;
    logic                stall;
    logic                empty;
    logic                mem_we;
    logic [STBUF_AW-1:0] mem_a;
    logic [STBUF_DW-1:0] mem_d;
    logic [STBUF_DW-1:0] mem_q;
    logic                mem_ready;

    modport slave (
        input  cpu_we, cpu_re, cpu_a, cpu_d, mem_q, mem_ready,
        output cpu_q, stall, empty, mem_we, mem_a, mem_d
    );

    modport master (
        output cpu_we, cpu_re, cpu_a, cpu_d, mem_q, mem_ready,
        input  cpu_q, stall, empty, mem_we, mem_a, mem_d
    );

endinterface

// File: rtl/stbuf_fwd_match.sv
// Youngest-match selector for store-to-load forwarding.
// Walks from oldest slot (tail) to youngest (tail-1) so the last hit wins.
module stbuf_fwd_match
    import dmem_stbuf_pkg::*;
#(
    parameter int DEPTH = STBUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  entry_t              ents [DEPTH],
    input  logic [PTR_W-1:0]    tail,
    input  logic [STBUF_AW-1:0] a,
    output logic                hit,
    output logic [STBUF_DW-1:0] data
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (ents[idx].valid && (ents[idx].addr == a)) begin
                hit  = 1'b1;
                data = ents[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer with in-order drain and load forwarding.
// Optional DMEM_STBUF_COALESCE_EN: same-address store merges into youngest entry.
module dmem_store_buffer
    import dmem_stbuf_pkg::*;
#(
    parameter int DEPTH = STBUF_DEPTH
) (
    input logic                clk,
    input logic                rst,
    dmem_store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t              ents [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                drain;
    logic                enq;
    logic                coal;
    logic                fwd_hit;
    logic [STBUF_DW-1:0] fwd_data;

    assign full      = (count == CNT_W'(DEPTH));
    assign bus.empty = (count == '0);
    assign drain     = !bus.empty && bus.mem_ready && !bus.cpu_re;

`ifdef DMEM_STBUF_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail - PTR_W'(1);
    // A merge into the head while it drains would be lost, so allocate instead.
    assign coal = bus.cpu_we && ents[youngest].valid &&
                  (ents[youngest].addr == bus.cpu_a) &&
                  !(drain && (youngest == head));
`else
    assign coal = 1'b0;
`endif

    assign enq       = bus.cpu_we && !full && !coal;
    assign bus.stall = bus.cpu_we && full && !coal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ents[i].valid <= 1'b0;
            end
        end else begin
            if (drain) begin
                ents[head].valid <= 1'b0;
                head             <= head + PTR_W'(1);
            end
            if (enq) begin
                ents[tail] <= '{valid: 1'b1, addr: bus.cpu_a, data: bus.cpu_d};
                tail       <= tail + PTR_W'(1);
            end
`ifdef DMEM_STBUF_COALESCE_EN
            if (coal) begin
                ents[youngest].data <= bus.cpu_d;
            end
`endif
            count <= count + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    stbuf_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .ents (ents),
        .tail (tail),
        .a    (bus.cpu_a),
        .hit  (fwd_hit),
        .data (fwd_data)
    );

    assign bus.cpu_q  = (bus.cpu_re && fwd_hit) ? fwd_data : bus.mem_q;
    assign bus.mem_we = drain;
    assign bus.mem_a  = bus.cpu_re ? bus.cpu_a : ents[head].addr;
    assign bus.mem_d  = ents[head].data;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer against a queue-level model.
module tb_dmem_store_buffer;
    import dmem_stbuf_pkg::*;

    localparam int DEPTH = STBUF_DEPTH;
    localparam int AW    = STBUF_AW;
    localparam int DW    = STBUF_DW;
    localparam int MEMW  = 1 << AW;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_mem = 1'b1;
    always #5 clk = ~clk;

    dmem_store_buffer_if bus ();

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    logic [DW-1:0] mem_arr [MEMW];
    logic [DW-1:0] ref_mem [MEMW];

    function automatic logic [DW-1:0] seed_val(input int i);
        return 32'hC0DE0000 | DW'(i);
    endfunction

    assign bus.mem_q = mem_arr[bus.mem_a];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEMW; i++) mem_arr[i] <= seed_val(i);
        end else if (bus.mem_we) begin
            mem_arr[bus.mem_a] <= bus.mem_d;
        end
    end

    int checks = 0;
    int failures = 0;
    st_t q[$];

    logic          obs_stall, obs_empty, obs_we;
    logic [AW-1:0] obs_a;
    logic [DW-1:0] obs_d, obs_q;
    logic          exp_stall, exp_empty, exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_q;

    // One bus cycle: drive, sample mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic we, input logic re, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy);
        int n;
        logic full_m, drn_m, coal_m, acc_m;
        @(negedge clk);
        bus.cpu_we = we;
        bus.cpu_re = re;
        bus.cpu_a = a;
        bus.cpu_d = d;
        bus.mem_ready = rdy;
        #2;
        n = q.size();
        full_m = (n == DEPTH);
        drn_m = (n > 0) && rdy && !re;
        coal_m = 1'b0;
`ifdef DMEM_STBUF_COALESCE_EN
        if (we && n > 0) begin
            if (q[n-1].a == a && !(drn_m && n == 1)) coal_m = 1'b1;
        end
`endif
        acc_m = we && !full_m && !coal_m;
        exp_stall = we && full_m && !coal_m;
        exp_empty = (n == 0);
        exp_we = drn_m;
        exp_a = re ? a : ((n > 0) ? q[0].a : '0);
        exp_d = (n > 0) ? q[0].d : '0;
        exp_q = ref_mem[a];
        for (int i = 0; i < n; i++) if (q[i].a == a) exp_q = q[i].d;
        obs_stall = bus.stall;
        obs_empty = bus.empty;
        obs_we = bus.mem_we;
        obs_a = bus.mem_a;
        obs_d = bus.mem_d;
        obs_q = bus.cpu_q;
        @(posedge clk);
        if (coal_m) q[n-1].d = d;
        if (drn_m) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (acc_m) q.push_back('{a: a, d: d});
    endtask

    task automatic flush();
        for (int i = 0; i < 4 * DEPTH + 4 && q.size() > 0; i++) cyc(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL flush_timeout pending=%0d required=0", q.size());
        end
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if (obs_empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty got=%0b required=1", obs_empty);
        end
    endtask

    task automatic test_reset();
        bus.cpu_we = 1'b1;
        bus.cpu_re = 1'b0;
        bus.cpu_a = '0;
        bus.cpu_d = '0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < MEMW; i++) ref_mem[i] = seed_val(i);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.empty, bus.mem_we, bus.stall} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags got empty/we/stall=%03b required=100",
                     {bus.empty, bus.mem_we, bus.stall});
        end
        @(negedge clk);
        init_mem = 1'b0;
        rst_n = 1'b1;
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_reset_midq();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, AW'(9 + i), 32'h5EED0000 | DW'(i), 1'b0);
        @(negedge clk);
        bus.cpu_we = 1'b1;
        bus.cpu_re = 1'b0;
        bus.mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.empty, bus.mem_we, bus.stall} !== 3'b100) begin
            failures++;
            $display("FAIL reset_midq_flags got empty/we/stall=%03b required=100",
                     {bus.empty, bus.mem_we, bus.stall});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.cpu_we = 1'b0;
        q.delete();
        cyc(1'b0, 1'b1, AW'(10), '0, 1'b0);
        checks++;
        if (obs_q !== seed_val(10)) begin
            failures++;
            $display("FAIL reset_load got=%h required=%h", obs_q, seed_val(10));
        end
        checks++;
        if (obs_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_drain got=%0b required=0", obs_we);
        end
    endtask

    task automatic test_forward_single();
        cyc(1'b1, 1'b0, AW'(5), 32'h11111111, 1'b0);
        cyc(1'b0, 1'b1, AW'(5), '0, 1'b0);
        checks++;
        if (obs_q !== 32'h11111111) begin
            failures++;
            $display("FAIL fwd_single_q got=%h required=11111111", obs_q);
        end
        checks++;
        if ({obs_we, obs_empty} !== 2'b00) begin
            failures++;
            $display("FAIL fwd_single_flags got we/empty=%02b required=00", {obs_we, obs_empty});
        end
        flush();
    endtask

    task automatic test_youngest();
        logic [DW-1:0] got[$];
        cyc(1'b1, 1'b0, AW'(3), 32'hA, 1'b0);
        cyc(1'b1, 1'b0, AW'(3), 32'hB, 1'b0);
        cyc(1'b0, 1'b1, AW'(3), '0, 1'b0);
        checks++;
        if (obs_q !== 32'hB) begin
            failures++;
            $display("FAIL youngest_q got=%h required=0000000b", obs_q);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
            if (obs_we && obs_a == AW'(3)) got.push_back(obs_d);
        end
`ifdef DMEM_STBUF_COALESCE_EN
        checks++;
        if (got.size() != 1 || got[0] !== 32'hB) begin
            failures++;
            $display("FAIL youngest_order writes=%0d first=%h required 1 write of b",
                     got.size(), (got.size() > 0) ? got[0] : '0);
        end
`else
        checks++;
        if (got.size() != 2 || got[0] !== 32'hA || got[1] !== 32'hB) begin
            failures++;
            $display("FAIL youngest_order writes=%0d required a then b", got.size());
        end
`endif
        flush();
    endtask

    task automatic test_full_stall();
        logic [AW-1:0] got[$];
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, AW'(i), 32'hF0000000 | DW'(i), 1'b0);
            checks++;
            if (obs_stall !== (i == 4)) begin
                failures++;
                $display("FAIL full_stall_%0d got=%0b required=%0b", i, obs_stall, (i == 4));
            end
        end
        cyc(1'b1, 1'b0, AW'(4), 32'hF0000004, 1'b1);
        checks++;
        if (obs_stall !== 1'b1) begin
            failures++;
            $display("FAIL full_stall_held got=%0b required=1", obs_stall);
        end
        if (obs_we) got.push_back(obs_a);
        cyc(1'b1, 1'b0, AW'(4), 32'hF0000004, 1'b1);
        checks++;
        if (obs_stall !== 1'b0) begin
            failures++;
            $display("FAIL full_stall_drop got=%0b required=0", obs_stall);
        end
        if (obs_we) got.push_back(obs_a);
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
            if (obs_we) got.push_back(obs_a);
        end
        checks++;
        if (got.size() != 5) begin
            failures++;
            $display("FAIL full_drain_count got=%0d required=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== AW'(i)) begin
                    failures++;
                    $display("FAIL full_drain_order idx=%0d got=%0d required=%0d", i, got[i], i);
                end
            end
        end
        flush();
    endtask

    task automatic test_load_blocks_drain();
        cyc(1'b1, 1'b0, AW'(20), 32'h20, 1'b0);
        cyc(1'b1, 1'b0, AW'(21), 32'h21, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, AW'(30 + i), '0, 1'b1);
            checks++;
            if (obs_we !== 1'b0 || obs_a !== AW'(30 + i)) begin
                failures++;
                $display("FAIL load_block got we=%0b a=%0d required we=0 a=%0d", obs_we, obs_a, 30 + i);
            end
        end
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if (obs_we !== 1'b1 || obs_a !== AW'(20)) begin
            failures++;
            $display("FAIL load_resume got we=%0b a=%0d required we=1 a=20", obs_we, obs_a);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, AW'(40 + i), 32'hB2B00000 | DW'(i), 1'b1);
            checks++;
            if (obs_stall !== 1'b0 || obs_we !== (i > 0) ||
                (i > 0 && obs_a !== AW'(40 + i - 1))) begin
                failures++;
                $display("FAIL b2b_%0d got stall=%0b we=%0b a=%0d", i, obs_stall, obs_we, obs_a);
            end
        end
        flush();
    endtask

`ifdef DMEM_STBUF_COALESCE_EN
    task automatic test_coalesce();
        logic [DW-1:0] got[$];
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, AW'(50 + i), 32'hC0A10000 | DW'(i), 1'b0);
        cyc(1'b1, 1'b0, AW'(50 + DEPTH - 1), 32'hDEADBEEF, 1'b0);
        checks++;
        if (obs_stall !== 1'b0) begin
            failures++;
            $display("FAIL coal_stall got=%0b required=0", obs_stall);
        end
        cyc(1'b1, 1'b0, AW'(60), 32'h60, 1'b0);
        checks++;
        if (obs_stall !== 1'b1) begin
            failures++;
            $display("FAIL coal_still_full got=%0b required=1", obs_stall);
        end
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
            if (obs_we && obs_a == AW'(50 + DEPTH - 1)) got.push_back(obs_d);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL coal_data writes=%0d required one write of deadbeef", got.size());
        end
        flush();
    endtask
`endif

    task automatic test_random();
        logic we, re, rdy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int op;
        for (int c = 0; c < 400; c++) begin
            op = int'($urandom_range(0, 7));
            we = (op <= 3) || (op == 6);
            re = (op == 4) || (op == 5) || (op == 6);
            rdy = $urandom_range(0, 1) == 1;
            a = AW'($urandom_range(0, 7));
            d = $urandom;
            cyc(we, re, a, d, rdy);
            checks++;
            if (obs_stall !== exp_stall || obs_empty !== exp_empty || obs_we !== exp_we) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d got stall/empty/we=%0b%0b%0b required=%0b%0b%0b",
                         c, obs_stall, obs_empty, obs_we, exp_stall, exp_empty, exp_we);
            end
            if (exp_we || re) begin
                checks++;
                if (obs_a !== exp_a || (exp_we && obs_d !== exp_d)) begin
                    failures++;
                    $display("FAIL rand_mem cyc=%0d got a=%0d d=%h required a=%0d d=%h",
                             c, obs_a, obs_d, exp_a, exp_d);
                end
            end
            if (re) begin
                checks++;
                if (obs_q !== exp_q) begin
                    failures++;
                    $display("FAIL rand_load cyc=%0d a=%0d got=%h required=%h", c, a, obs_q, exp_q);
                end
            end
        end
        flush();
    endtask

    task automatic test_memory_image();
        int bad;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < MEMW; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL memory_image differing_words=%0d required=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_forward_single();
        test_youngest();
        test_full_stall();
        test_load_blocks_drain();
        test_back_to_back();
`ifdef DMEM_STBUF_COALESCE_EN
        test_coalesce();
`endif
        test_random();
        test_reset_midq();
        test_memory_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
